pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller for the five-stage OpenMIPS core. Collects stall requests from ID (load-use) and EX (multi-cycle ops) plus exception/ERET reports from MEM. Drives the per-stage stall vector consumed by pc_reg and all pipeline registers, plus a registered flush pulse with redirect PC. Sequences exception entry (freeze, flush, refill) and watches for runaway EX stalls.

Parameters:
EXC_VECTOR, 32'h0000_0020, redirect PC for any non-ERET exception
ERET_CODE, 32'h0000_000e, excepttype_i value meaning ERET (redirect to EPC)
MAX_STALL, 64, consecutive EX-stall cycles before stall_timeout_o pulses (2..65535)
REFILL_CYCLES, 2, cycles after flush during which exceptions are masked (1..15)

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-low reset
stallreq_from_id  in  1  ID load-use stall request
stallreq_from_ex  in  1  EX multi-cycle stall request
excepttype_i  in  32  exception code from MEM; 0 = none
cp0_epc_i  in  32  EPC from CP0, used on ERET
stall_o  out  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1 = hold
flush_o  out  1  one-cycle pipeline flush pulse (registered)
new_pc_o  out  32  redirect target, valid while flush_o=1
stall_timeout_o  out  1  one-cycle pulse, EX stall exceeded MAX_STALL
stall_cycles_o  out  32  stall perf counter (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=RUN, stall_o=0, flush_o=0, new_pc_o=0, stall_timeout_o=0, all counters 0. Reset mid-exception or mid-stall aborts the sequence; no flush pulse is issued afterwards.
- stall_o is combinational from state and current inputs (same-cycle effect). flush_o, new_pc_o and stall_timeout_o are registered.
- Priority within a cycle: exception > EX stall > ID stall.
- Encodings: ID stall 6'b000111; EX stall 6'b001111; exception freeze 6'b111111; none 6'b000000.
- RUN:
  - excepttype_i!=0: stall_o=111111; latch new_pc (cp0_epc_i if ==ERET_CODE, else EXC_VECTOR); next FLUSH.
  - else if stallreq_from_ex: stall_o=001111; stall_cnt<=1; next EXSTALL.
  - else if stallreq_from_id: stall_o=000111; stay RUN.
  - else stall_o=0.
- EXSTALL:
  - exception handled as in RUN; stall_cnt cleared.
  - stallreq_from_ex=1: stall_o=001111; stall_cnt++ (saturates at MAX_STALL). stall_timeout_o pulses for exactly one cycle on the cycle after stall_cnt first reaches MAX_STALL; no re-pulse until the stall ends.
  - stallreq_from_ex=0: stall_o per ID request; stall_cnt<=0; next RUN.
- FLUSH (exactly 1 cycle): flush_o=1, new_pc_o=latched value, stall_o=0, all inputs ignored; refill_cnt<=REFILL_CYCLES; next REFILL.
- REFILL: flush_o=0; excepttype_i masked; ID/EX stall requests honoured as in RUN (EX request enters EXSTALL early); refill_cnt-- each cycle; at 0 next RUN.
- new_pc_o holds its last value outside FLUSH.
- Exception detect to flush_o high: 1 cycle latency. Freeze cycle keeps the faulting instruction in MEM.

Optional Feature:
STALL_PERF_CNT_EN: when defined, stall_cycles_o counts cycles with stall_o!=0. It saturates at 32'hFFFF_FFFF and is cleared only by reset. When not defined, stall_cycles_o is tied to 0 and no counter flops exist.

Decomposition:
- Shared define.v gets StallBus (5:0) plus stall encodings StallNone/StallId/StallEx/StallAll, ExcVector, ExcEret and the state encodings RUN/EXSTALL/FLUSH/REFILL.
- One sub-module: pipe_ctrl_wdog holds the EX-stall counter, saturation and timeout pulse (inputs clk, rst, active, clear).

Test Plan:
- Reset released, no requests -> stall_o=000000, flush_o=0, new_pc_o=0 for 10 cycles.
- stallreq_from_id=1 and stallreq_from_ex=1 in the same cycle -> stall_o=001111. Drop EX only -> stall_o=000111 that cycle.
- excepttype_i=32'h8 for 1 cycle -> stall_o=111111 that cycle; next cycle flush_o=1, new_pc_o=32'h20. Exception re-asserted for the following 2 cycles is ignored (no second flush).
- excepttype_i=32'h0000000e, cp0_epc_i=32'h0000_1234 -> flush_o=1 with new_pc_o=32'h0000_1234 one cycle later.
- stallreq_from_ex held 70 cycles, MAX_STALL=64 -> exactly one stall_timeout_o pulse; stall_o=001111 throughout. Exception arriving mid-stall -> flush sequence runs and timeout counter clears.
- rst asserted during the FLUSH cycle -> flush_o drops immediately, state RUN after release. With STALL_PERF_CNT_EN defined, stall_cycles_o equals the number of stalled cycles driven.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared stall-bus encodings, FSM states and default redirect constants for pipe_ctrl.
package pipe_ctrl_pkg;

  typedef logic [5:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_ALL  = 6'b111111;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
  localparam logic [31:0] EXC_ERET_DEF   = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_EXSTALL = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_REFILL  = 2'd3
  } state_t;

  // EX hazard outranks the ID load-use hazard when both are raised.
  function automatic stall_bus_t stall_for_req(input logic id_req, input logic ex_req);
    if (ex_req)
      return STALL_EX;
    else if (id_req)
      return STALL_ID;
    else
      return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Runaway EX-stall watchdog: saturating cycle counter with a single timeout pulse per stall episode.
module pipe_ctrl_wdog #(
  parameter int MAX_STALL = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic clear,
  output logic timeout_o
);

  localparam logic [15:0] LP_MAX = 16'(MAX_STALL);

  logic [15:0] r_cnt;
  logic        r_timeout;

  // Saturation at LP_MAX means the pulse condition cannot recur until clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (clear) begin
        r_cnt <= 16'd0;
      end else if (active) begin
        if (r_cnt != LP_MAX)
          r_cnt <= r_cnt + 16'd1;
        if (r_cnt == LP_MAX - 16'd1)
          r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// OpenMIPS pipeline controller: stall vector, exception freeze/flush/refill, EX-stall watchdog.
// Optional stall perf counter enabled by defining STALL_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_CODE     = EXC_ERET_DEF,
  parameter int          MAX_STALL     = 64,
  parameter int          REFILL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cycles_o
);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_refill_cnt;
  logic [3:0]  w_refill_nxt;
  logic [31:0] r_new_pc;
  logic        r_flush;
  logic        w_exc;
  logic        w_take_exc;
  logic        w_ex_active;
  stall_bus_t  w_stall;

  assign w_exc = (excepttype_i != 32'd0);

  always_comb begin
    w_next       = r_state;
    w_stall      = STALL_NONE;
    w_take_exc   = 1'b0;
    w_ex_active  = 1'b0;
    w_refill_nxt = r_refill_cnt;
    case (r_state)
      ST_RUN, ST_EXSTALL: begin
        if (w_exc) begin
          w_stall    = STALL_ALL;
          w_take_exc = 1'b1;
          w_next     = ST_FLUSH;
        end else if (stallreq_from_ex) begin
          w_stall     = STALL_EX;
          w_ex_active = 1'b1;
          w_next      = ST_EXSTALL;
        end else begin
          w_stall = stall_for_req(stallreq_from_id, 1'b0);
          w_next  = ST_RUN;
        end
      end
      ST_FLUSH: begin
        w_refill_nxt = 4'(REFILL_CYCLES);
        w_next       = ST_REFILL;
      end
      ST_REFILL: begin
        // Exceptions are masked here: the refetched instructions are still in flight.
        w_refill_nxt = r_refill_cnt - 4'd1;
        if (stallreq_from_ex) begin
          w_stall     = STALL_EX;
          w_ex_active = 1'b1;
          w_next      = ST_EXSTALL;
        end else begin
          w_stall = stall_for_req(stallreq_from_id, 1'b0);
          w_next  = (r_refill_cnt <= 4'd1) ? ST_RUN : ST_REFILL;
        end
      end
      default: w_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_refill_cnt <= 4'd0;
      r_flush      <= 1'b0;
      r_new_pc     <= 32'd0;
    end else begin
      r_state      <= w_next;
      r_refill_cnt <= w_refill_nxt;
      r_flush      <= w_take_exc;
      if (w_take_exc)
        r_new_pc <= (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
    end
  end

  pipe_ctrl_wdog #(
    .MAX_STALL (MAX_STALL)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .active    (w_ex_active),
    .clear     (!w_ex_active),
    .timeout_o (stall_timeout_o)
  );

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cycles <= 32'd0;
    else if ((w_stall != STALL_NONE) && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles_o = r_stall_cycles;
`else
  assign stall_cycles_o = 32'd0;
`endif

  assign stall_o  = w_stall;
  assign flush_o  = r_flush;
  assign new_pc_o = r_new_pc;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: redirect PCs and timeout pulse slots are queued when driven, checked when seen.
module tb_pipe_ctrl;

  localparam int MAX_STALL = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_from_id = 1'b0;
  logic        stallreq_from_ex = 1'b0;
  logic [31:0] excepttype_i = 32'd0;
  logic [31:0] cp0_epc_i = 32'd0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cycles_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] q_pc[$];
  int          q_to[$];

  pipe_ctrl #(
    .EXC_VECTOR    (32'h0000_0020),
    .ERET_CODE     (32'h0000_000e),
    .MAX_STALL     (MAX_STALL),
    .REFILL_CYCLES (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .excepttype_i     (excepttype_i),
    .cp0_epc_i        (cp0_epc_i),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .new_pc_o         (new_pc_o),
    .stall_timeout_o  (stall_timeout_o),
    .stall_cycles_o   (stall_cycles_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Inputs change on the falling edge; outputs are sampled 1ns later, mid-cycle.
  task automatic drive(input logic id, input logic ex, input logic [31:0] exc, input logic [31:0] epc);
    @(negedge clk);
    stallreq_from_id = id;
    stallreq_from_ex = ex;
    excepttype_i     = exc;
    cp0_epc_i        = epc;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL reset_stall got %b want 000000", stall_o); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush_o); end
    checks++; if (new_pc_o !== 32'd0) begin errors++; $display("FAIL reset_newpc got %h want 0", new_pc_o); end
    checks++; if (stall_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", stall_timeout_o); end
    checks++; if (stall_cycles_o !== 32'd0) begin errors++; $display("FAIL reset_cycles got %h want 0", stall_cycles_o); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL idle_stall[%0d] got %b want 000000", i, stall_o); end
      checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL idle_flush[%0d] got %b want 0", i, flush_o); end
      checks++; if (new_pc_o !== 32'd0) begin errors++; $display("FAIL idle_newpc[%0d] got %h want 0", i, new_pc_o); end
    end
  endtask

  task automatic test_stall_priority;
    drive(1'b1, 1'b1, 32'd0, 32'd0);
    checks++; if (stall_o !== 6'b001111) begin errors++; $display("FAIL id_ex_both got %b want 001111", stall_o); end
    drive(1'b1, 1'b0, 32'd0, 32'd0);
    checks++; if (stall_o !== 6'b000111) begin errors++; $display("FAIL ex_dropped got %b want 000111", stall_o); end
    drive(1'b1, 1'b0, 32'd0, 32'd0);
    checks++; if (stall_o !== 6'b000111) begin errors++; $display("FAIL id_only got %b want 000111", stall_o); end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL none got %b want 000000", stall_o); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL stall_no_flush got %b want 0", flush_o); end
  endtask

  task automatic test_exception;
    logic [31:0] exp_pc;
    drive(1'b1, 1'b1, 32'h8, 32'd0);
    checks++; if (stall_o !== 6'b111111) begin errors++; $display("FAIL exc_freeze got %b want 111111", stall_o); end
    q_pc.push_back(32'h0000_0020);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL exc_flush got %b want 1", flush_o); end
    checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL exc_flush_stall got %b want 000000", stall_o); end
    exp_pc = q_pc.pop_front();
    checks++; if (new_pc_o !== exp_pc) begin errors++; $display("FAIL exc_newpc got %h want %h", new_pc_o, exp_pc); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h8, 32'd0);
      checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL refill_masked_stall[%0d] got %b want 000000", i, stall_o); end
      checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL refill_flush[%0d] got %b want 0", i, flush_o); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL no_second_flush[%0d] got %b want 0", i, flush_o); end
      checks++; if (new_pc_o !== 32'h0000_0020) begin errors++; $display("FAIL newpc_hold[%0d] got %h want 00000020", i, new_pc_o); end
    end
  endtask

  task automatic test_eret;
    logic [31:0] exp_pc;
    drive(1'b0, 1'b0, 32'h0000_000e, 32'h0000_1234);
    checks++; if (stall_o !== 6'b111111) begin errors++; $display("FAIL eret_freeze got %b want 111111", stall_o); end
    q_pc.push_back(32'h0000_1234);
    drive(1'b0, 1'b0, 32'd0, 32'hdead_beef);
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL eret_flush got %b want 1", flush_o); end
    exp_pc = q_pc.pop_front();
    checks++; if (new_pc_o !== exp_pc) begin errors++; $display("FAIL eret_newpc got %h want %h", new_pc_o, exp_pc); end
    idle(3);
  endtask

  task automatic test_timeout;
    int pulses;
    int exp_slot;
    logic [31:0] exp_pc;
    pulses = 0;
    q_to.push_back(MAX_STALL + 1);
    for (int i = 1; i <= 70; i++) begin
      drive(1'b0, 1'b1, 32'd0, 32'd0);
      checks++; if (stall_o !== 6'b001111) begin errors++; $display("FAIL long_stall[%0d] got %b want 001111", i, stall_o); end
      if (stall_timeout_o === 1'b1) begin
        pulses++;
        checks++;
        if (q_to.size() == 0) begin
          errors++; $display("FAIL timeout_extra got pulse at cycle %0d want none", i);
        end else begin
          exp_slot = q_to.pop_front();
          if (i != exp_slot) begin errors++; $display("FAIL timeout_slot got %0d want %0d", i, exp_slot); end
        end
      end
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    if (stall_timeout_o === 1'b1) pulses++;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    if (stall_timeout_o === 1'b1) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_count got %0d want 1", pulses); end
    q_to.delete();

    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 32'd0, 32'd0);
      if (stall_timeout_o === 1'b1) pulses++;
    end
    drive(1'b0, 1'b1, 32'h8, 32'd0);
    checks++; if (stall_o !== 6'b111111) begin errors++; $display("FAIL midstall_exc got %b want 111111", stall_o); end
    q_pc.push_back(32'h0000_0020);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL midstall_flush got %b want 1", flush_o); end
    exp_pc = q_pc.pop_front();
    checks++; if (new_pc_o !== exp_pc) begin errors++; $display("FAIL midstall_newpc got %h want %h", new_pc_o, exp_pc); end
    idle(3);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 32'd0, 32'd0);
      if (stall_timeout_o === 1'b1) pulses++;
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    if (stall_timeout_o === 1'b1) pulses++;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (pulses != 0) begin errors++; $display("FAIL wdog_cleared got %0d pulses want 0", pulses); end
  endtask

  task automatic test_reset_in_flush;
    logic [31:0] exp_pc;
    drive(1'b0, 1'b0, 32'h8, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL rflush_pre got %b want 1", flush_o); end
    rst = 1'b0;
    #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL rflush_drop got %b want 0", flush_o); end
    checks++; if (new_pc_o !== 32'd0) begin errors++; $display("FAIL rflush_newpc got %h want 0", new_pc_o); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL rflush_no_pulse got %b want 0", flush_o); end
    drive(1'b0, 1'b0, 32'h8, 32'd0);
    checks++; if (stall_o !== 6'b111111) begin errors++; $display("FAIL rflush_run_state got %b want 111111", stall_o); end
    q_pc.push_back(32'h0000_0020);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    exp_pc = q_pc.pop_front();
    checks++; if ((flush_o !== 1'b1) || (new_pc_o !== exp_pc)) begin
      errors++; $display("FAIL rflush_refire got flush=%b pc=%h want flush=1 pc=%h", flush_o, new_pc_o, exp_pc);
    end
    idle(3);
  endtask

  task automatic test_perf_cnt;
    int exp_cycles;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_cycles = 0;
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 32'd0, 32'd0); exp_cycles++; end
    idle(3);
    for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1, 32'd0, 32'd0); exp_cycles++; end
    drive(1'b0, 1'b0, 32'h8, 32'd0);
    exp_cycles++;
    idle(4);
`ifdef STALL_PERF_CNT_EN
    checks++; if (stall_cycles_o !== 32'(exp_cycles)) begin errors++; $display("FAIL perf_cycles got %0d want %0d", stall_cycles_o, exp_cycles); end
    idle(3);
    checks++; if (stall_cycles_o !== 32'(exp_cycles)) begin errors++; $display("FAIL perf_hold got %0d want %0d", stall_cycles_o, exp_cycles); end
`else
    checks++; if (stall_cycles_o !== 32'd0) begin errors++; $display("FAIL perf_tied got %0d want 0 (stalled %0d)", stall_cycles_o, exp_cycles); end
`endif
  endtask

  initial begin
    test_reset();
    test_stall_priority();
    test_exception();
    test_eret();
    test_timeout();
    test_reset_in_flush();
    test_perf_cnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
